// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the 8255 PPI bus master
// Purpose: bus-cycle state encoding, PPI register addresses, control-word
// field positions and a helper that maps a bus phase to its length.
// Ports: none (package).
package ppi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] PPI_ADDR_PA   = 2'd0;
    localparam logic [1:0] PPI_ADDR_PB   = 2'd1;
    localparam logic [1:0] PPI_ADDR_PC   = 2'd2;
    localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

    // Control word: bit 7 selects mode-set (1) or bit set/reset (0).
    localparam int CW_MODE_SET_BIT = 7;
    localparam int CW_BSR_SEL_MSB  = 3;
    localparam int CW_BSR_SEL_LSB  = 1;
    localparam int CW_BSR_SET_BIT  = 0;

    // Mode-set I/O direction bits (1 = input).
    localparam int DIR_PA_BIT       = 4;
    localparam int DIR_PC_UPPER_BIT = 3;
    localparam int DIR_PB_BIT       = 1;
    localparam int DIR_PC_LOWER_BIT = 0;

    // Length in cycles of the phase being entered; IDLE has no length.
    function automatic logic [3:0] phase_len(input state_t s, input int su,
                                             input int pu, input int ho);
        case (s)
            ST_SETUP:  phase_len = 4'(su);
            ST_STROBE: phase_len = 4'(pu);
            ST_HOLD:   phase_len = 4'(ho);
            default:   phase_len = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ppi_bus_timer.sv
// rtl/ppi_bus_timer.sv - loadable 4-bit phase down-counter
// Purpose: counts the cycles spent in one bus phase.
// Ports: clk/rst (async active-high), load + load_val reload the count,
//        tc is high while the count is at its last cycle (1, or 0 when idle).
module ppi_bus_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt <= 4'd1);

endmodule

// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - valid/ready to 8255 PPI CPU-side bus initiator
// Purpose: runs one SETUP/STROBE/HOLD bus cycle per accepted request.
// Ports: CLK, RESET (async active-high); req_valid/req_ready/req_write/
//        req_addr/req_wdata request side; done pulse + rsp_rdata response;
//        CS/RD/WR/A/D_out/D_oe/D_in PPI pins. All outputs except req_ready
//        are registered.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rsp_rdata,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [1:0] A,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);

    state_t state, next_state;
    logic   accept;
    logic   tc;
    logic   wr_lat;
    logic   cur_write;
    logic   cs_nx, rd_nx, wr_nx, oe_nx, done_nx, cap_nx;

    assign req_ready = (state == ST_IDLE) && !RESET;
    assign accept    = req_valid && req_ready;

    // Reload on every state change so each phase gets its full length.
    ppi_bus_timer u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (next_state != state),
        .load_val (phase_len(next_state, SETUP_CYC, PULSE_CYC, HOLD_CYC)),
        .tc       (tc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = (SETUP_CYC != 0) ? ST_SETUP : ST_STROBE;
            ST_SETUP:  if (tc) next_state = ST_STROBE;
            ST_STROBE: if (tc) next_state = (HOLD_CYC != 0) ? ST_HOLD : ST_IDLE;
            ST_HOLD:   if (tc) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Pin values are derived from the state being entered so they change
    // on the same edge as the state itself.
    always_comb begin
        cur_write = accept ? req_write : wr_lat;
        cs_nx     = (next_state == ST_IDLE);
        wr_nx     = !((next_state == ST_STROBE) && cur_write);
        rd_nx     = !((next_state == ST_STROBE) && !cur_write);
        oe_nx     = (next_state != ST_IDLE) && cur_write;
        done_nx   = (state != ST_IDLE) && (next_state == ST_IDLE);
        // Capture on the edge that ends the last strobe cycle, RD still low.
        cap_nx    = (state == ST_STROBE) && tc && !wr_lat;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CS        <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            D_oe      <= 1'b0;
            done      <= 1'b0;
            A         <= 2'd0;
            D_out     <= 8'd0;
            rsp_rdata <= 8'd0;
            wr_lat    <= 1'b0;
        end else begin
            CS   <= cs_nx;
            RD   <= rd_nx;
            WR   <= wr_nx;
            D_oe <= oe_nx;
            done <= done_nx;
            // A and D_out move only at acceptance, so they hold while idle.
            if (accept) begin
                A      <= req_addr;
                D_out  <= req_wdata;
                wr_lat <= req_write;
            end
            if (cap_nx) begin
                rsp_rdata <= D_in;
            end
        end
    end

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb/tb_ppi_bus_master.sv - directed self-checking bench for ppi_bus_master
module tb_ppi_bus_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_wdata = 8'd0, D_in = 8'd0;
    logic       req_ready, done, CS, RD, WR, D_oe;
    logic [7:0] rsp_rdata, D_out;
    logic [1:0] A;

    logic       RESET2 = 1'b1;
    logic       req_valid2 = 1'b0, req_write2 = 1'b0;
    logic [1:0] req_addr2 = 2'd0;
    logic [7:0] req_wdata2 = 8'd0, D_in2 = 8'd0;
    logic       req_ready2, done2, CS2, RD2, WR2, D_oe2;
    logic [7:0] rsp_rdata2, D_out2;
    logic [1:0] A2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    ppi_bus_master dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .CS(CS), .RD(RD), .WR(WR),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
    );

    ppi_bus_master #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) dut_fast (
        .CLK(CLK), .RESET(RESET2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .done(done2), .rsp_rdata(rsp_rdata2), .CS(CS2), .RD(RD2), .WR(WR2),
        .A(A2), .D_out(D_out2), .D_oe(D_oe2), .D_in(D_in2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one default-timing transaction whose request is already being
    // driven; at the first sample it presents the next request (nv/nw/na/nd).
    task automatic txn(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] rdv, input logic [7:0] rsp_exp,
                       input logic nv, input logic nw, input logic [1:0] na,
                       input logic [7:0] nd);
        logic strobe;
        if (!w) D_in = rdv;
        for (int n = 1; n <= 5; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                req_valid = nv; req_write = nw; req_addr = na; req_wdata = nd;
            end
            strobe = (n == 2) || (n == 3);
            // {CS, RD, WR, D_oe, done, req_ready}
            check($sformatf("ctl_n%0d", n), {26'd0, CS, RD, WR, D_oe, done, req_ready},
                  {26'd0, (n == 5), !(strobe && !w), !(strobe && w), (w && n < 5), (n == 5), (n == 5)});
            check($sformatf("addr_n%0d", n), {30'd0, A}, {30'd0, a});
            if (w) check($sformatf("dout_n%0d", n), {24'd0, D_out}, {24'd0, d});
            if (n == 4 && !w) D_in = 8'h00;
        end
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, rsp_exp});
    endtask

    initial begin
        // Reset held for 3 cycles on both instances.
        @(negedge CLK);
        check("rst_ctl", {26'd0, CS, RD, WR, D_oe, done, req_ready}, 32'b111000);
        check("rst_a_dout", {22'd0, A, D_out}, 32'd0);
        check("rst_rsp", {24'd0, rsp_rdata}, 32'd0);
        check("rst2_ctl", {26'd0, CS2, RD2, WR2, D_oe2, done2, req_ready2}, 32'b111000);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        RESET2 = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(negedge CLK);
        check("ready_idle", {31'd0, req_ready}, 32'd1);

        // Control word write, then a read accepted in its done cycle,
        // then back-to-back writes with req_valid held.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'h80;
        txn(1'b1, 2'd3, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        txn(1'b0, 2'd0, 8'h00, 8'hF0, 8'hF0, 1'b1, 1'b1, 2'd1, 8'hFC);
        txn(1'b1, 2'd1, 8'hFC, 8'h00, 8'hF0, 1'b1, 1'b1, 2'd2, 8'hAA);
        txn(1'b1, 2'd2, 8'hAA, 8'h00, 8'hF0, 1'b0, 1'b0, 2'd0, 8'h00);

        // Abort a write in the middle of STROBE.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h55;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        check("abort_pre", {29'd0, CS, WR, D_oe}, 32'b001);
        #2;
        RESET = 1'b1;
        #1;
        check("abort_ctl", {26'd0, CS, RD, WR, D_oe, done, req_ready}, 32'b111000);
        check("abort_a_dout", {22'd0, A, D_out}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("abort_nodone%0d", k), {31'd0, done}, 32'd0);
        end
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_nodone_rel", {30'd0, done, req_ready}, 32'b01);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2; req_wdata = 8'h00;
        txn(1'b0, 2'd2, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 2'd0, 8'h00);

        // Zero setup/hold, single-cycle strobe: BSR write 0x0F to control.
        req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 2'd3; req_wdata2 = 8'h0F;
        @(negedge CLK);
        req_valid2 = 1'b0;
        // {CS, WR, RD, D_oe, done, req_ready}
        check("fast_strobe", {26'd0, CS2, WR2, RD2, D_oe2, done2, req_ready2}, 32'b001100);
        check("fast_a_dout", {22'd0, A2, D_out2}, {22'd0, 2'd3, 8'h0F});
        @(negedge CLK);
        check("fast_done", {26'd0, CS2, WR2, RD2, D_oe2, done2, req_ready2}, 32'b111011);
        @(negedge CLK);
        check("fast_done_once", {31'd0, done2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
